// File: rtl/decode_stage.sv
// RV32I decode stage: register file with write-through bypass, field/immediate
// decode, and a one-deep decode/execute pipeline register with stall and flush.
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] FD_Inst_code,
  input  logic [31:0] FD_PC,
  input  logic        FD_Valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        WB_En,
  input  logic [4:0]  WB_Rd,
  input  logic [31:0] WB_Data,
  output logic        DE_Valid,
  output logic [31:0] DE_PC,
  output logic [6:0]  DE_Opcode,
  output logic [2:0]  DE_Funct3,
  output logic [6:0]  DE_Funct7,
  output logic [4:0]  DE_Rd,
  output logic [31:0] DE_Rs1_Data,
  output logic [31:0] DE_Rs2_Data,
  output logic [31:0] DE_Imm,
  output logic        DE_Illegal
);

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL
  } fmt_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        illegal;
  } de_t;

  logic [31:0] inst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        wb_write;
  fmt_e        fmt;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  de_t         dec;
  de_t         de_q;
  de_t         de_d;

  assign inst     = FD_Inst_code;
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];
  assign wb_write = WB_En && (WB_Rd != 5'd0);

  // Register file: entry 0 is kept at zero so x0 reads need no special port.
  always_comb begin
    rf_d = rf_q;
    if (wb_write) rf_d[WB_Rd] = WB_Data;
    rf_d[0] = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Same-cycle writeback wins over stored data so a dependent decode sees it.
  always_comb begin
    rs1_data = rf_q[rs1_addr];
    if (wb_write && (WB_Rd == rs1_addr)) rs1_data = WB_Data;
    if (rs1_addr == 5'd0) rs1_data = '0;
    rs2_data = rf_q[rs2_addr];
    if (wb_write && (WB_Rd == rs2_addr)) rs2_data = WB_Data;
    if (rs2_addr == 5'd0) rs2_data = '0;
  end

  always_comb begin
    case (inst[6:0])
      7'b0110011:                                     fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111:                         fmt = FMT_I;
      7'b0100011:                                     fmt = FMT_S;
      7'b1100011:                                     fmt = FMT_B;
      7'b0110111, 7'b0010111:                         fmt = FMT_U;
      7'b1101111:                                     fmt = FMT_J;
      default:                                        fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    case (fmt)
      FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {inst[31:12], 12'b0};
      FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_comb begin
    dec          = '0;
    dec.valid    = FD_Valid;
    dec.pc       = FD_PC;
    dec.opcode   = inst[6:0];
    dec.funct3   = inst[14:12];
    dec.funct7   = inst[31:25];
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.imm      = imm;
    dec.illegal  = (fmt == FMT_ILL);
    if (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) dec.rd = inst[11:7];
  end

  // Pipeline control: flush inserts a bubble and overrides stall; stall holds
  // every field (operands included) while the register file keeps writing.
  always_comb begin
    de_d = de_q;
    if (flush) begin
      de_d = '0;
    end else if (!stall) begin
      de_d = dec;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      de_q    <= '0;
      de_q.pc <= RESET_PC;
    end else begin
      de_q <= de_d;
    end
  end

  assign DE_Valid    = de_q.valid;
  assign DE_PC       = de_q.pc;
  assign DE_Opcode   = de_q.opcode;
  assign DE_Funct3   = de_q.funct3;
  assign DE_Funct7   = de_q.funct7;
  assign DE_Rd       = de_q.rd;
  assign DE_Rs1_Data = de_q.rs1_data;
  assign DE_Rs2_Data = de_q.rs2_data;
  assign DE_Imm      = de_q.imm;
  assign DE_Illegal  = de_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed spec vectors plus randomized writeback/decode
// traffic, checked against a register-file model through an expected queue.
module tb_decode_stage;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

  logic        clock;
  logic        reset;
  logic [31:0] FD_Inst_code;
  logic [31:0] FD_PC;
  logic        FD_Valid;
  logic        stall;
  logic        flush;
  logic        WB_En;
  logic [4:0]  WB_Rd;
  logic [31:0] WB_Data;
  logic        DE_Valid;
  logic [31:0] DE_PC;
  logic [6:0]  DE_Opcode;
  logic [2:0]  DE_Funct3;
  logic [6:0]  DE_Funct7;
  logic [4:0]  DE_Rd;
  logic [31:0] DE_Rs1_Data;
  logic [31:0] DE_Rs2_Data;
  logic [31:0] DE_Imm;
  logic        DE_Illegal;

  decode_stage #(.RESET_PC(TB_RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .FD_Inst_code(FD_Inst_code), .FD_PC(FD_PC), .FD_Valid(FD_Valid),
    .stall(stall), .flush(flush),
    .WB_En(WB_En), .WB_Rd(WB_Rd), .WB_Data(WB_Data),
    .DE_Valid(DE_Valid), .DE_PC(DE_PC), .DE_Opcode(DE_Opcode),
    .DE_Funct3(DE_Funct3), .DE_Funct7(DE_Funct7), .DE_Rd(DE_Rd),
    .DE_Rs1_Data(DE_Rs1_Data), .DE_Rs2_Data(DE_Rs2_Data),
    .DE_Imm(DE_Imm), .DE_Illegal(DE_Illegal)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  logic [151:0] exp_q[$];
  logic [151:0] exp;
  logic [151:0] obs;
  logic [31:0]  model_rf [32];
  int           tests_run;
  int           tests_failed;

  assign obs = {DE_Valid, DE_PC, DE_Opcode, DE_Funct3, DE_Funct7, DE_Rd,
                DE_Rs1_Data, DE_Rs2_Data, DE_Imm, DE_Illegal};

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic v);
    FD_Inst_code = inst;
    FD_PC        = pc;
    FD_Valid     = v;
  endtask

  // Commit the modelled writeback, then step past the edge to sample.
  task automatic tick();
    if (WB_En && WB_Rd != 5'd0) model_rf[WB_Rd] = WB_Data;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rf_exp(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (WB_En && WB_Rd == a) return WB_Data;
    return model_rf[a];
  endfunction

  function automatic logic [151:0] mk(input logic v, input logic [31:0] pc,
                                      input logic [31:0] inst, input logic [4:0] rd,
                                      input logic [31:0] r1, input logic [31:0] r2,
                                      input logic [31:0] imm, input logic ill);
    return {v, pc, inst[6:0], inst[14:12], inst[31:25], rd, r1, r2, imm, ill};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] inst;
    drive(32'h0050_0093, 32'h100, 1'b1);
    for (int i = 1; i < 32; i++) begin
      WB_En = 1'b1; WB_Rd = 5'(i); WB_Data = $urandom | 32'h1;
      tick();
    end
    WB_En = 1'b0;
    stall = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    exp_q.push_back(mk(1'b0, TB_RESET_PC, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0));
    exp = exp_q.pop_front();
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL reset_async got=%h exp=%h", obs, exp);
    end
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    tick();
    exp_q.push_back(mk(1'b0, TB_RESET_PC, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0));
    exp = exp_q.pop_front();
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL reset_held got=%h exp=%h", obs, exp);
    end
    stall = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 1; i < 32; i++) begin
      inst = {7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'b0110011};
      drive(inst, 32'(i * 4), 1'b1);
      exp_q.push_back(mk(1'b1, 32'(i * 4), inst, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0));
      tick();
      exp = exp_q.pop_front();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL reset_rf_clear x%0d got=%h exp=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_addi();
    drive(32'h0050_0093, 32'h100, 1'b1);
    exp_q.push_back(mk(1'b1, 32'h100, 32'h0050_0093, 5'd1, 32'd0, rf_exp(5'd5), 32'd5, 1'b0));
    tick();
    exp = exp_q.pop_front();
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL addi got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] insts [4];
    logic        wbe   [4];
    logic [4:0]  wbr   [4];
    logic [31:0] opnd  [4];
    insts = '{32'h0021_01B3, 32'h0021_01B3, 32'h0000_01B3, 32'h0000_01B3};
    wbe   = '{1'b1, 1'b0, 1'b1, 1'b0};
    wbr   = '{5'd2, 5'd2, 5'd0, 5'd0};
    opnd  = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 32'd0};
    for (int i = 0; i < 4; i++) begin
      WB_En = wbe[i]; WB_Rd = wbr[i];
      WB_Data = (i < 2) ? 32'hDEAD_BEEF : 32'hFFFF_FFFF;
      drive(insts[i], 32'h104 + 32'(i * 4), 1'b1);
      exp_q.push_back(mk(1'b1, 32'h104 + 32'(i * 4), insts[i], 5'd3, opnd[i], opnd[i],
                         32'd0, 1'b0));
      tick();
      exp = exp_q.pop_front();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL bypass step%0d got=%h exp=%h", i, obs, exp);
      end
    end
    WB_En = 1'b0;
  endtask

  task automatic test_immediates();
    vec_t vecs [11];
    vecs = '{
      '{32'hFE00_0EE3, 5'd0, 32'hFFFF_FFFC, 1'b0},
      '{32'h1234_52B7, 5'd5, 32'h1234_5000, 1'b0},
      '{32'h0000_007F, 5'd0, 32'h0000_0000, 1'b1},
      '{32'h0080_00EF, 5'd1, 32'h0000_0008, 1'b0},
      '{32'hFE20_AC23, 5'd0, 32'hFFFF_FFF8, 1'b0},
      '{32'hFFFF_F397, 5'd7, 32'hFFFF_F000, 1'b0},
      '{32'hFFF1_A203, 5'd4, 32'hFFFF_FFFF, 1'b0},
      '{32'h0FF0_000F, 5'd0, 32'h0000_00FF, 1'b0},
      '{32'h4083_8333, 5'd6, 32'h0000_0000, 1'b0},
      '{32'h7FF1_00E7, 5'd1, 32'h0000_07FF, 1'b0},
      '{32'hFFFF_FFFB, 5'd0, 32'h0000_0000, 1'b1}
    };
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].inst, 32'h400 + 32'(i * 4), 1'b1);
      exp_q.push_back(mk(1'b1, 32'h400 + 32'(i * 4), vecs[i].inst, vecs[i].rd,
                         rf_exp(vecs[i].inst[19:15]), rf_exp(vecs[i].inst[24:20]),
                         vecs[i].imm, vecs[i].ill));
      tick();
      exp = exp_q.pop_front();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL imm %h got=%h exp=%h", vecs[i].inst, obs, exp);
      end
    end
  endtask

  task automatic test_stall_flush();
    logic [151:0] hold;
    drive(32'h0050_0093, 32'h200, 1'b1);
    hold = mk(1'b1, 32'h200, 32'h0050_0093, 5'd1, 32'd0, rf_exp(5'd5), 32'd5, 1'b0);
    exp_q.push_back(hold);
    tick();
    exp = exp_q.pop_front();
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL stall_load got=%h exp=%h", obs, exp);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, 1'b1);
      WB_En = 1'b1; WB_Rd = 5'd5; WB_Data = $urandom | 32'h100;
      exp_q.push_back(hold);
      tick();
      exp = exp_q.pop_front();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL stall_hold cycle%0d got=%h exp=%h", i, obs, exp);
      end
    end
    WB_En = 1'b0;
    flush = 1'b1;
    drive(32'h0050_0093, 32'h204, 1'b1);
    exp_q.push_back(152'd0);
    tick();
    exp = exp_q.pop_front();
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL stall_flush got=%h exp=%h", obs, exp);
    end
    stall = 1'b0;
    flush = 1'b0;
    drive(32'h0050_0093, 32'h208, 1'b1);
    exp_q.push_back(mk(1'b1, 32'h208, 32'h0050_0093, 5'd1, 32'd0, model_rf[5], 32'd5, 1'b0));
    tick();
    exp = exp_q.pop_front();
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL stall_release got=%h exp=%h", obs, exp);
    end
    flush = 1'b1;
    exp_q.push_back(152'd0);
    tick();
    exp = exp_q.pop_front();
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL flush_only got=%h exp=%h", obs, exp);
    end
    flush = 1'b0;
  endtask

  task automatic test_fd_valid();
    drive(32'h0050_0093, 32'h300, 1'b0);
    exp_q.push_back(mk(1'b0, 32'h300, 32'h0050_0093, 5'd1, 32'd0, rf_exp(5'd5), 32'd5, 1'b0));
    tick();
    exp = exp_q.pop_front();
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL fd_valid0 got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        v;
    for (int i = 0; i < 48; i++) begin
      WB_En   = 1'($urandom_range(0, 1));
      WB_Rd   = 5'($urandom_range(0, 7));
      WB_Data = $urandom;
      v       = 1'($urandom_range(0, 3) != 0);
      rd      = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0) begin
        inst = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                3'($urandom), rd, 7'b0110011};
        imm  = 32'd0;
      end else begin
        imm  = 32'(signed'(12'($urandom)));
        inst = {imm[11:0], 5'($urandom_range(0, 7)), 3'b000, rd, 7'b0010011};
      end
      drive(inst, 32'h800 + 32'(i * 4), v);
      exp_q.push_back(mk(v, 32'h800 + 32'(i * 4), inst, rd, rf_exp(inst[19:15]),
                         rf_exp(inst[24:20]), imm, 1'b0));
      tick();
      exp = exp_q.pop_front();
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL back_to_back %0d inst=%h got=%h exp=%h", i, inst, obs, exp);
      end
    end
    WB_En = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    stall        = 1'b0;
    flush        = 1'b0;
    WB_En        = 1'b0;
    WB_Rd        = 5'd0;
    WB_Data      = 32'd0;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    drive(32'd0, 32'd0, 1'b0);
    #12;
    reset = 1'b0;
    test_reset();
    test_addi();
    test_bypass();
    test_immediates();
    test_stall_flush();
    test_fd_valid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
